// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst}; flush beats push, push+pop keeps count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared only on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC generation, credit-limited imem requests, response
// buffering and redirect flush with discard of stale in-flight responses.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]   count, live, drop, outstanding;
  logic [CW+1:0]   credit;
  fetch_entry_t    head, wdata;
  logic            full, empty, pop, req_fire, rsp_keep, rsp_drop;

  assign pop         = inst_valid && inst_ready;
  assign outstanding = live + drop;
  // Slots a new request would need: buffered after this pop plus in flight.
  assign credit = (CW+2)'(count) + (CW+2)'(live) + (CW+2)'(drop) - (CW+2)'(pop);

  assign imem_req_valid = !reset && !redirect_valid && (credit < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop != '0);
  assign rsp_keep = imem_rsp_valid && (drop == '0) && (live != '0);
  assign wdata    = '{pc: rsp_pc, inst: imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_keep && (!full || pop)),
    .wdata (wdata),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      live     <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
      rsp_pc   <= align_pc(redirect_pc);
      live     <= '0;
      // Everything still in flight becomes stale; a response landing now is eaten here.
      drop     <= outstanding - CW'(imem_rsp_valid && (outstanding != '0));
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      if (rsp_keep) rsp_pc   <= rsp_pc + PC_STEP;
      live <= live + CW'(req_fire) - CW'(rsp_keep);
      drop <= drop - CW'(rsp_drop);
    end
  end

  assign inst_valid    = !empty;
  assign inst_data     = head.inst;
  assign inst_pc       = head.pc;
  assign inst_pc_plus4 = head.pc + PC_STEP;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order imem model, stream-level scoreboard, directed
// scenarios with literal expectations, then a randomised latency/backpressure run.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h100;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc, inst_pc_plus4;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory: in-order, one response per cycle, latency 1 + extra.
  typedef struct { logic [31:0] a; int due; } pend_t;
  pend_t pend[$];
  bit rand_mode = 0;
  int lat_extra = 0;
  int last_due = 0;
  int dnew;
  logic mfire;
  logic [31:0] mad;

  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mfire = imem_req_valid && imem_req_ready;
      mad   = imem_req_addr;
      @(posedge clk); #2;
      if (reset) begin
        pend.delete();
        last_due = 0;
        imem_rsp_valid = 1'b0;
      end else begin
        if (mfire) begin
          dnew = cyc + (rand_mode ? int'($urandom_range(0, 5)) : lat_extra);
          if (dnew <= last_due) dnew = last_due + 1;
          last_due = dnew;
          pend.push_back('{a: mad, due: dnew});
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memf(pend[0].a);
          void'(pend.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
      imem_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Stream model: requests are consecutive words from the last target, and the
  // consumed instruction stream is the same sequence with the matching data.
  logic [31:0] m_fetch = RPC;
  logic [31:0] m_exp = RPC;
  int outst = 0;
  int pops = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk1("req_valid_in_reset", imem_req_valid, 1'b0);
      m_fetch = RPC; m_exp = RPC; outst = 0;
    end else begin
      if (redirect_valid) chk1("req_valid_on_redirect", imem_req_valid, 1'b0);
      if (imem_req_valid) chk("req_addr", imem_req_addr, m_fetch);
      if (imem_req_valid && imem_req_ready) begin
        chk1("inflight_le_depth", (outst + 1) <= DEPTH, 1'b1);
        m_fetch += 32'd4;
        outst++;
      end
      if (imem_rsp_valid) outst--;
      if (inst_valid) begin
        chk("inst_pc", inst_pc, m_exp);
        chk("inst_data", inst_data, memf(m_exp));
        chk("inst_pc_plus4", inst_pc_plus4, m_exp + 32'd4);
        if (inst_ready) begin
          m_exp += 32'd4;
          pops++;
        end
      end
      if (redirect_valid) begin
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_exp   = m_fetch;
      end
    end
  end

  task automatic nx(); @(posedge clk); #1; endtask
  task automatic ng(); @(negedge clk); endtask

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1; ng();
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_pc_plus4", inst_pc_plus4, 32'h4);

    // Streaming from RESET_PC.
    nx(); reset = 1'b0; ng();
    chk1("c0_req_valid", imem_req_valid, 1'b1);
    chk("c0_req_addr", imem_req_addr, 32'h100);
    chk1("c0_inst_valid", inst_valid, 1'b0);
    nx(); ng();
    chk("c1_req_addr", imem_req_addr, 32'h104);
    chk1("c1_inst_valid", inst_valid, 1'b0);
    for (int k = 2; k < 8; k++) begin
      nx(); ng();
      chk1("stream_valid", inst_valid, 1'b1);
      chk("stream_pc", inst_pc, 32'h100 + 32'(4 * (k - 2)));
    end

    // Decode backpressure from a fresh start.
    nx(); reset = 1'b1; inst_ready = 1'b0; ng();
    nx(); reset = 1'b0; ng();
    repeat (10) begin nx(); ng(); end
    chk1("bp_req_valid", imem_req_valid, 1'b0);
    chk1("bp_inst_valid", inst_valid, 1'b1);
    chk("bp_head", inst_pc, 32'h100);
    nx(); inst_ready = 1'b1; ng(); chk("rel_pc0", inst_pc, 32'h100);
    nx(); ng(); chk("rel_pc1", inst_pc, 32'h104);
    nx(); ng(); chk("rel_pc2", inst_pc, 32'h108);
    nx(); inst_ready = 1'b0; ng();
    nx(); ng();
    chk("refill_head", inst_pc, 32'h10C);

    // Redirect while 0x114 is still outstanding (2-cycle memory for it).
    nx(); inst_ready = 1'b1; lat_extra = 1; ng();
    chk("pre_redir_req", imem_req_addr, 32'h114);
    nx(); inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200; ng();
    chk1("redir_req_valid", imem_req_valid, 1'b0);
    nx(); redirect_valid = 1'b0; inst_ready = 1'b1; lat_extra = 0; ng();
    chk1("r1_inst_valid", inst_valid, 1'b0);
    chk1("r1_req_valid", imem_req_valid, 1'b1);
    chk("r1_req_addr", imem_req_addr, 32'h200);
    nx(); ng(); chk1("r2_inst_valid", inst_valid, 1'b0);
    nx(); ng();
    chk1("r3_inst_valid", inst_valid, 1'b1);
    chk("r3_inst_pc", inst_pc, 32'h200);

    // Misaligned target coinciding with a response and a pop.
    repeat (3) begin nx(); ng(); end
    nx(); redirect_valid = 1'b1; redirect_pc = 32'h203; ng();
    chk1("mis_pop_cycle", inst_valid, 1'b1);
    nx(); redirect_valid = 1'b0; ng();
    chk("mis_r1_addr", imem_req_addr, 32'h200);
    chk1("mis_r1_inst_valid", inst_valid, 1'b0);
    nx(); ng();
    nx(); ng();
    chk("mis_r3_pc", inst_pc, 32'h200);
    nx(); ng(); chk("mis_r4_pc", inst_pc, 32'h204);

    // Address wrap.
    nx(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; ng();
    nx(); redirect_valid = 1'b0; ng(); chk("wrap_a0", imem_req_addr, 32'hFFFF_FFF8);
    nx(); ng(); chk("wrap_a1", imem_req_addr, 32'hFFFF_FFFC);
    nx(); ng();
    chk1("wrap_a2_valid", imem_req_valid, 1'b1);
    chk("wrap_a2", imem_req_addr, 32'h0);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
    nx(); ng(); chk("wrap_plus4", inst_pc_plus4, 32'h0);

    // Reset mid-stream with slow memory so requests are pending.
    nx(); lat_extra = 3; inst_ready = 1'b0; ng();
    repeat (2) begin nx(); ng(); end
    nx(); reset = 1'b1; ng();
    nx(); reset = 1'b0; lat_extra = 0; inst_ready = 1'b1; ng();
    chk1("mrst_req_valid", imem_req_valid, 1'b1);
    chk("mrst_req_addr", imem_req_addr, 32'h100);
    chk1("mrst_inst_valid", inst_valid, 1'b0);
    chk("mrst_inst_data", inst_data, 32'h0);
    chk("mrst_inst_pc", inst_pc, 32'h0);
    chk("mrst_plus4", inst_pc_plus4, 32'h4);
    nx(); ng(); chk("mrst_req_addr1", imem_req_addr, 32'h104);
    nx(); ng(); chk("mrst_first_pc", inst_pc, 32'h100);

    // Random latency, memory stalls, decode stalls and redirects.
    rand_mode = 1;
    repeat (400) begin
      nx();
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      ng();
    end
    nx(); redirect_valid = 1'b0; rand_mode = 0; inst_ready = 1'b1; ng();
    repeat (20) begin nx(); ng(); end
    chk1("rand_progress", pops > 80, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
